// File: rtl/cma_adapt_ctrl.sv
// cma_adapt_ctrl: sequences equalizer coefficient init, flush, CMA acquisition, DD tracking and freeze.
module cma_adapt_ctrl #(
  parameter int NB_MU      = 16,
  parameter int NB_ERR     = 18,
  parameter int NB_CNT     = 16,
  parameter int INIT_LEN   = 21,
  parameter int ACQ_LEN    = 4096,
  parameter int LOCK_LEN   = 256,
  parameter int UNLOCK_LEN = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_run,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic                     i_freeze,
  input  logic signed [NB_MU-1:0]  i_mu_acq,
  input  logic signed [NB_MU-1:0]  i_mu_trk,
  input  logic        [NB_ERR-1:0] i_err_abs,
  input  logic        [NB_ERR-1:0] i_err_thr,
  output logic                     o_coeff_init,
  output logic                     o_adapt_en,
  output logic signed [NB_MU-1:0]  o_mu,
  output logic                     o_dd_mode,
  output logic                     o_locked,
  output logic        [2:0]        o_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, FLUSH = 3'd1, ACQ = 3'd2, TRACK = 3'd3, HOLD = 3'd4} state_t;
  localparam int M0      = INIT_LEN > ACQ_LEN ? INIT_LEN : ACQ_LEN;
  localparam int M1      = LOCK_LEN > UNLOCK_LEN ? LOCK_LEN : UNLOCK_LEN;
  localparam int MAX_LEN = M0 > M1 ? M0 : M1;
  if (NB_CNT < $clog2(MAX_LEN + 1)) begin : g_cnt_too_narrow
    $error("NB_CNT too narrow for the configured lengths");
  end
  localparam logic [NB_CNT-1:0] INIT_C   = NB_CNT'(INIT_LEN);
  localparam logic [NB_CNT-1:0] ACQ_C    = NB_CNT'(ACQ_LEN);
  localparam logic [NB_CNT-1:0] LOCK_C   = NB_CNT'(LOCK_LEN);
  localparam logic [NB_CNT-1:0] UNLOCK_C = NB_CNT'(UNLOCK_LEN);
  state_t state_q, state_d, ret_q, ret_d;
  logic [NB_CNT-1:0] flush_q, flush_d, acq_q, acq_d, good_q, good_d, bad_q, bad_d;
  logic coeff_init_q, adapt_q, dd_q, locked_q;
  logic signed [NB_MU-1:0] mu_q;
  logic sym, sym_good, sym_bad;
  assign sym      = i_en && i_valid;
  assign sym_good = sym && (i_err_abs < i_err_thr);
  assign sym_bad  = sym && (i_err_abs >= i_err_thr);
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    flush_d = flush_q;
    acq_d   = acq_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (!i_run || state_q == IDLE) begin
      state_d = i_run ? FLUSH : IDLE;
      flush_d = '0;
      acq_d   = '0;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        FLUSH: if (sym) begin
          flush_d = flush_q + 1'b1;
          if (flush_d == INIT_C) begin
            state_d = ACQ;
            flush_d = '0;
          end
        end
        ACQ: if (i_freeze) begin
          ret_d   = ACQ;
          state_d = HOLD;
        end else begin
          acq_d  = (sym && acq_q != ACQ_C) ? acq_q + 1'b1 : acq_q;
          good_d = sym_bad ? '0 : (sym_good && good_q != LOCK_C) ? good_q + 1'b1 : good_q;
          if (acq_d == ACQ_C && good_d == LOCK_C) begin
            state_d = TRACK;
            bad_d   = '0;
          end
        end
        TRACK: if (i_freeze) begin
          ret_d   = TRACK;
          state_d = HOLD;
        end else begin
          bad_d = sym_bad ? bad_q + 1'b1 : sym_good ? '0 : bad_q;
          // losing lock restarts acquisition from scratch
          if (bad_d == UNLOCK_C) begin
            state_d = ACQ;
            acq_d   = '0;
            good_d  = '0;
            bad_d   = '0;
          end
        end
        HOLD: state_d = i_freeze ? HOLD : ret_q;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      flush_q      <= '0;
      acq_q        <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      coeff_init_q <= 1'b0;
      adapt_q      <= 1'b0;
      mu_q         <= '0;
      dd_q         <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      flush_q      <= flush_d;
      acq_q        <= acq_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      coeff_init_q <= state_q == IDLE && state_d == FLUSH;
      adapt_q      <= state_d == ACQ || state_d == TRACK;
      mu_q         <= state_d == ACQ ? i_mu_acq : state_d == TRACK ? i_mu_trk : '0;
      dd_q         <= state_d == HOLD ? dd_q : state_d == TRACK;
      locked_q     <= state_d == HOLD ? locked_q : state_d == TRACK;
    end
  end
  assign o_coeff_init = coeff_init_q;
  assign o_adapt_en   = adapt_q;
  assign o_mu         = mu_q;
  assign o_dd_mode    = dd_q;
  assign o_locked     = locked_q;
  assign o_state      = state_q;
endmodule

// File: tb/tb_cma_adapt_ctrl.sv
// tb_cma_adapt_ctrl: directed checks of startup, lock/unlock, freeze, valid gating and abort.
module tb_cma_adapt_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, en = 1'b0, valid = 1'b0, freeze = 1'b0;
  logic signed [15:0] mu_acq = 16'sd64, mu_trk = 16'sd16;
  logic [17:0] err_abs = 18'd10, err_thr = 18'd1000;
  logic coeff_init, adapt_en, dd_mode, locked;
  logic signed [15:0] mu;
  logic [2:0] st;
  int n_chk = 0, n_err = 0;

  cma_adapt_ctrl #(.INIT_LEN(4), .ACQ_LEN(8), .LOCK_LEN(4), .UNLOCK_LEN(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_en(en), .i_valid(valid), .i_freeze(freeze),
    .i_mu_acq(mu_acq), .i_mu_trk(mu_trk), .i_err_abs(err_abs), .i_err_thr(err_thr),
    .o_coeff_init(coeff_init), .o_adapt_en(adapt_en), .o_mu(mu), .o_dd_mode(dd_mode),
    .o_locked(locked), .o_state(st)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int ci, input int ae,
                         input int m, input int dd, input int lk);
    chk({tag, ".state"}, 32'(st), s);
    chk({tag, ".coeff_init"}, 32'(coeff_init), ci);
    chk({tag, ".adapt_en"}, 32'(adapt_en), ae);
    chk({tag, ".mu"}, 32'(mu), m);
    chk({tag, ".dd_mode"}, 32'(dd_mode), dd);
    chk({tag, ".locked"}, 32'(locked), lk);
  endtask

  initial begin
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    run = 1'b1; en = 1'b1; valid = 1'b1;
    #10 rst = 1'b0;
    tick(); chk_all("flush_first", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk_all("flush", 1, 0, 0, 0, 0, 0); end
    tick(); chk_all("acq_entry", 2, 0, 1, 64, 0, 0);
    for (int i = 0; i < 7; i++) begin tick(); chk("acq_stay", 32'(st), 2); end
    tick(); chk_all("track_entry", 3, 0, 1, 16, 1, 1);
    err_abs = 18'd1000;
    tick(); chk("track_bad1", 32'(st), 3);
    tick(); chk("track_bad2", 32'(st), 3);
    err_abs = 18'd10;
    tick(); chk("track_good", 32'(st), 3);
    err_abs = 18'd1000;
    tick(); chk("track_bad_after_good", 32'(st), 3);
    freeze = 1'b1;
    tick(); chk_all("hold", 4, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin tick(); chk("hold_stay", 32'(st), 4); end
    freeze = 1'b0;
    tick(); chk_all("unfreeze", 3, 0, 1, 16, 1, 1);
    tick(); chk("track_bad_post_hold", 32'(st), 3);
    tick(); chk_all("unlock", 2, 0, 1, 64, 0, 0);
    for (int i = 0; i < 50; i++) begin
      err_abs = (i % 2 == 1) ? 18'd2000 : 18'd10;
      tick(); chk("nolock_state", 32'(st), 2); chk("nolock_locked", 32'(locked), 0);
    end
    err_abs = 18'd10;
    for (int i = 0; i < 3; i++) begin tick(); chk("relock_wait", 32'(st), 2); end
    tick(); chk_all("relock", 3, 0, 1, 16, 1, 1);
    run = 1'b0;
    tick(); chk_all("run_off", 0, 0, 0, 0, 0, 0);
    run = 1'b1; valid = 1'b0;
    tick(); chk_all("restart", 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      valid = (k % 2 == 1);
      tick(); chk("valid_gate", 32'(st), (k == 7) ? 2 : 1);
    end
    en = 1'b0; valid = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); chk("en_stall", 32'(st), 2); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("acq_resume", 32'(st), 2); end
    run = 1'b0;
    tick(); chk_all("abort", 0, 0, 0, 0, 0, 0);
    run = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk_all("track_again", 3, 0, 1, 16, 1, 1);
    #3 rst = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    tick(); chk("reset_held", 32'(st), 0);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cma_adapt_ctrl.md
Name: cma_adapt_ctrl

Overview:
- Sequences startup and adaptation of the CMA/DD adaptive FIR equalizer: coefficient init, pipeline flush, high-mu acquisition, low-mu decision-directed tracking, and freeze.
- Sits beside the equalizer top level and drives its step size, adaptation enable, coefficient-init strobe and error-mode select.
- Monitors the equalizer error magnitude to declare and drop lock.

Parameters:
NB_MU, 16, width of step-size inputs and output (signed, same format as equalizer mu)
NB_ERR, 18, width of unsigned error magnitude and threshold
NB_CNT, 16, width of internal symbol counters
INIT_LEN, 21, valid samples to flush after coefficient init (equals FIR_LEN)
ACQ_LEN, 4096, minimum valid symbols spent in acquisition
LOCK_LEN, 256, consecutive good symbols required to declare lock
UNLOCK_LEN, 64, consecutive bad symbols in tracking that force re-acquisition

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_run  in  1  level; 1 = run the sequence, 0 = return to IDLE
i_en  in  1  global enable
i_valid  in  1  sample valid; a symbol counts only when i_en && i_valid
i_freeze  in  1  level; suspend adaptation while high
i_mu_acq  in  NB_MU  signed step size for acquisition
i_mu_trk  in  NB_MU  signed step size for tracking
i_err_abs  in  NB_ERR  unsigned |error| from equalizer, aligned with the current valid symbol
i_err_thr  in  NB_ERR  unsigned good/bad threshold
o_coeff_init  out  1  one-cycle strobe: load center-tap init coefficients
o_adapt_en  out  1  coefficient update enable
o_mu  out  NB_MU  step size to equalizer
o_dd_mode  out  1  0 = CMA error, 1 = decision-directed error
o_locked  out  1  lock indicator
o_state  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, FLUSH=1, ACQ=2, TRACK=3, HOLD=4. All outputs are registered and decoded from the registered state.
- Reset (async): state=IDLE, all counters 0, o_coeff_init=0, o_adapt_en=0, o_mu=0, o_dd_mode=0, o_locked=0, o_state=0. Reset mid-operation aborts immediately, regardless of state.
- sym = i_en && i_valid. good = sym && (i_err_abs < i_err_thr). bad = sym && (i_err_abs >= i_err_thr). Equality counts as bad.
- i_run=0 forces IDLE on the next edge from any state, with highest priority after reset. Counters are cleared and o_locked drops.
- IDLE, i_run=1: go to FLUSH; o_coeff_init=1 for exactly the first FLUSH cycle.
- FLUSH: o_adapt_en=0, o_mu=0. The flush counter increments on sym. On the sym that makes the count INIT_LEN, go to ACQ next edge. i_freeze is ignored in FLUSH.
- ACQ outputs: o_adapt_en=1, o_mu=i_mu_acq (sampled each cycle), o_dd_mode=0, o_locked=0.
- ACQ counters:
  - acq_cnt increments on sym and saturates at ACQ_LEN.
  - good_run increments on good, clears on bad, and saturates at LOCK_LEN.
- ACQ exit: go to TRACK on the edge after the cycle where acq_cnt==ACQ_LEN and good_run==LOCK_LEN both hold, including values updated by the current symbol. If ACQ_LEN elapses without lock, stay in ACQ indefinitely.
- TRACK outputs: o_adapt_en=1, o_mu=i_mu_trk, o_dd_mode=1, o_locked=1.
- TRACK counter: bad_run increments on bad and clears on good.
- TRACK exit: on the bad that makes bad_run==UNLOCK_LEN, go to ACQ. acq_cnt, good_run and bad_run clear, and o_locked=0 from the next cycle.
- i_freeze=1 in ACQ or TRACK: go to HOLD, storing the return state.
  - HOLD outputs: o_adapt_en=0, o_mu=0; o_dd_mode and o_locked keep their pre-freeze values.
  - Counters hold and sym is not counted in HOLD.
  - i_freeze=0: return to the stored state with counters intact.
- Priority in one cycle: reset > i_run=0 > i_freeze > counter-driven transitions. A symbol arriving in the same cycle as freeze entry is not counted.
- State transitions take effect one clock after the qualifying input cycle; output latency = 1 cycle.
- Counters never wrap: NB_CNT must hold max(INIT_LEN, ACQ_LEN, LOCK_LEN, UNLOCK_LEN). Checked by elaboration assertion.

Test Plan:
- All scenarios use INIT_LEN=4, ACQ_LEN=8, LOCK_LEN=4, UNLOCK_LEN=3, i_mu_acq=64, i_mu_trk=16, i_err_thr=1000.
- Startup: reset, then i_run=1, continuous sym, i_err_abs=10 -> o_coeff_init high 1 cycle; FLUSH for 4 syms; ACQ with o_mu=64 for 8 syms; then o_state=3, o_mu=16, o_dd_mode=1, o_locked=1.
- No lock: in ACQ, i_err_abs alternates 10/2000 for 50 syms -> remains o_state=2, o_locked=0. Then 4 consecutive values of 10 -> TRACK.
- Unlock: in TRACK, i_err_abs=1000 (equal to threshold) for 3 syms -> o_state=2, o_locked=0, o_mu=64. With 2 bad then 1 good, stays in TRACK.
- Freeze: i_freeze high 5 cycles in TRACK with i_valid=1 -> o_state=4, o_adapt_en=0, o_mu=0, o_locked=1; on release returns to TRACK with bad_run unchanged.
- Valid gating: i_valid toggles 1/0 during FLUSH -> ACQ reached only after 4 valid cycles (8 clocks). Holding i_en=0 stalls all counters.
- Abort: i_run=0 mid-ACQ -> IDLE next edge, outputs 0. Async i_reset asserted between clock edges in TRACK -> outputs 0 immediately, before the next clock edge.
